// File: rtl/key_encode42.sv
// key_encode42: debounced active-low 4-key priority encoder with one-cycle report strobe.
// Define KEY_ENC_REPEAT_EN to compile in hold-to-repeat reporting.
module key_encode42 #(
    parameter int DEB_CYC    = 240000,
    parameter int REPEAT_DLY = 6000000,
    parameter int REPEAT_PER = 1200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_key_n,
    output logic [1:0] o_code,
    output logic       o_valid,
    output logic [3:0] o_pressed
);
    localparam int CW = $clog2(DEB_CYC) > 0 ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYC - 1);
    logic [3:0]    r_sync1, r_sync2, r_cand, r_deb, r_pressed_q;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_code;
    logic          r_valid;
    logic [3:0]    w_new;
    logic          w_event;
    logic [1:0]    w_enc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 4'b1111;
            r_sync2     <= 4'b1111;
            r_cand      <= 4'b1111;
            r_deb       <= 4'b1111;
            r_cnt       <= '0;
            r_pressed_q <= 4'b0000;
        end else begin
            r_sync1     <= i_key_n;
            r_sync2     <= r_sync1;
            r_pressed_q <= o_pressed;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CMAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == CMAX) r_deb <= r_cand;
        end
    end
    assign o_pressed = ~r_deb;
    assign w_new     = o_pressed & ~r_pressed_q;
    assign w_event   = |w_new;
    assign w_enc     = w_new[3] ? 2'd3 : w_new[2] ? 2'd2 : w_new[1] ? 2'd1 : 2'd0;
`ifdef KEY_ENC_REPEAT_EN
    localparam int RMAX = REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER;
    localparam int RW = $clog2(RMAX) > 0 ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLYM = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PERM = RW'(REPEAT_PER - 1);
    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
    state_t        r_state;
    logic [RW-1:0] r_rcnt;
    // A fresh press always wins over a repeat due in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_code  <= 2'b00;
            r_valid <= 1'b0;
        end else if (w_event) begin
            r_state <= HOLD;
            r_rcnt  <= '0;
            r_code  <= w_enc;
            r_valid <= 1'b1;
        end else if (r_state == IDLE || !o_pressed[r_code]) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_valid <= 1'b0;
        end else if (r_rcnt == (r_state == HOLD ? DLYM : PERM)) begin
            r_state <= RPT;
            r_rcnt  <= '0;
            r_valid <= 1'b1;
        end else begin
            r_rcnt  <= r_rcnt + 1'b1;
            r_valid <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= 2'b00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_event;
            if (w_event) r_code <= w_enc;
        end
    end
`endif
    assign o_code  = r_code;
    assign o_valid = r_valid;
endmodule

// File: tb/tb_key_encode42.sv
// tb_key_encode42: directed checks of key_encode42 with DEB_CYC=8, REPEAT_DLY=40, REPEAT_PER=10.
module tb_key_encode42;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'b1111;
    logic [1:0] code;
    logic       valid;
    logic [3:0] pressed;
    int         total = 0, bad = 0, cyc = 0, nv = 0, n0 = 0, c0 = 0;
    logic [1:0] last_code = 2'b00;
    logic [3:0] last_pr = 4'b0000, any_pr = 4'b0000;
    int         vq[$];

    key_encode42 #(.DEB_CYC(8), .REPEAT_DLY(40), .REPEAT_PER(10)) dut (
        .clk(clk), .rst_n(rst_n), .i_key_n(key_n),
        .o_code(code), .o_valid(valid), .o_pressed(pressed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (valid) begin
            nv++;
            last_code = code;
            last_pr = pressed;
            vq.push_back(cyc);
        end
        any_pr = any_pr | pressed;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_n(3);
        chk("rst_code", code, 0);
        chk("rst_valid", valid, 0);
        chk("rst_pressed", pressed, 0);
        rst_n = 1'b1;
        wait_n(2);
        // single key1 press: pressed after edge 11, valid exactly at edge 12
        n0 = nv;
        key_n = 4'b1101;
        wait_n(10);
        chk("t1_pr_e10", pressed, 0);
        wait_n(1);
        chk("t1_pr_e11", pressed, 4'b0010);
        chk("t1_v_e11", valid, 0);
        wait_n(1);
        chk("t1_v_e12", valid, 1);
        chk("t1_code", code, 1);
        chk("t1_pr_e12", pressed, 4'b0010);
        wait_n(1);
        chk("t1_v_e13", valid, 0);
        wait_n(10);
        chk("t1_count", nv - n0, 1);
        key_n = 4'b1111;
        wait_n(20);
        chk("t1_rel_count", nv - n0, 1);
        chk("t1_rel_pr", pressed, 0);
        chk("t1_code_hold", code, 1);
        // keys 3 and 0 together
        n0 = nv;
        key_n = 4'b0110;
        wait_n(20);
        chk("t2_count", nv - n0, 1);
        chk("t2_code", last_code, 3);
        chk("t2_pr", pressed, 4'b1001);
        wait_n(20);
        chk("t2_no_key0", nv - n0, 1);
        key_n = 4'b1111;
        wait_n(20);
        // key0 pressed while key1 held
        n0 = nv;
        key_n = 4'b1101;
        wait_n(20);
        key_n = 4'b1100;
        wait_n(20);
        chk("t3_count", nv - n0, 2);
        chk("t3_code", last_code, 0);
        chk("t3_pr", last_pr, 4'b0011);
        key_n = 4'b1111;
        wait_n(20);
        // short glitches on key2
        n0 = nv;
        any_pr = 4'b0000;
        repeat (4) begin
            key_n = 4'b1011;
            wait_n(5);
            key_n = 4'b1111;
            wait_n(3);
        end
        wait_n(20);
        chk("t4_count", nv - n0, 0);
        chk("t4_pr", any_pr, 0);
        // reset in mid-debounce after code was set to 3
        key_n = 4'b0111;
        wait_n(20);
        key_n = 4'b1111;
        wait_n(20);
        chk("t5_pre_code", code, 3);
        key_n = 4'b1110;
        wait_n(8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_code", code, 0);
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_pr", pressed, 0);
        wait_n(2);
        rst_n = 1'b1;
        n0 = nv;
        wait_n(11);
        chk("t5_v_e11", valid, 0);
        chk("t5_early", nv - n0, 0);
        wait_n(1);
        chk("t5_v_e12", valid, 1);
        chk("t5_code", code, 0);
        key_n = 4'b1111;
        wait_n(20);
        // key2 held for 100 cycles
        n0 = nv;
        vq.delete();
        c0 = cyc;
        key_n = 4'b1011;
        wait_n(100);
        key_n = 4'b1111;
        wait_n(40);
        chk("t6_first", vq.size() > 0 ? vq[0] - c0 : -1, 12);
        chk("t6_code", last_code, 2);
`ifdef KEY_ENC_REPEAT_EN
        chk("t6_count", nv - n0, 7);
        chk("t6_second", vq.size() > 1 ? vq[1] - c0 : -1, 52);
        chk("t6_third", vq.size() > 2 ? vq[2] - c0 : -1, 62);
        chk("t6_last", vq.size() > 6 ? vq[6] - c0 : -1, 102);
`else
        chk("t6_count", nv - n0, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
